// File: rtl/bist_pkg.sv
// Shared types and default constants for the BIST engine and its MISR.
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_RUN,
        ST_FLUSH,
        ST_COMPARE,
        ST_DONE
    } bist_state_t;

    typedef logic [15:0] pattern_cnt_t;

    localparam logic [12:0] DEFAULT_LFSR_TAPS = 13'h1B00;
    localparam logic [15:0] DEFAULT_MISR_POLY = 16'h1021;

endpackage

// File: rtl/bist_if.sv
// Control, status and CUT-facing signals of the BIST engine.
// The slave side is the engine; the master side is the system plus the CUT.
interface bist_if #(
    parameter int WIDTH = 6,
    parameter int SIG_W = 16
);
    logic             start;
    logic             learn;
    logic             abort;
    logic [WIDTH-1:0] tpg_a;
    logic [WIDTH-1:0] tpg_b;
    logic             tpg_cin;
    logic [WIDTH:0]   cut_resp;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] signature;
    logic [15:0]      pattern_idx;

    modport master (
        output start, learn, abort, cut_resp,
        input  tpg_a, tpg_b, tpg_cin, busy, done, pass, signature, pattern_idx
    );

    modport slave (
        input  start, learn, abort, cut_resp,
        output tpg_a, tpg_b, tpg_cin, busy, done, pass, signature, pattern_idx
    );
endinterface

// File: rtl/bist_misr.sv
// Galois multi-input signature register: shift, conditional polynomial
// feedback and XOR of the zero-extended response word.
module bist_misr
    import bist_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = DEFAULT_MISR_POLY,
    parameter int               IN_W  = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [IN_W-1:0]  data,
    output logic [SIG_W-1:0] sig
);

    // Clear wins over enable so a new run always starts from a zero signature.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= '0;
        end else if (clear) begin
            sig <= '0;
        end else if (enable) begin
            sig <= {sig[SIG_W-2:0], 1'b0}
                 ^ (sig[SIG_W-1] ? POLY : '0)
                 ^ SIG_W'(data);
        end
    end

endmodule

// File: rtl/bist_engine.sv
// LFSR-driven self-test engine for an adder-class CUT: generates patterns,
// compacts responses in a MISR and learns or checks a golden signature.
module bist_engine
    import bist_pkg::*;
#(
    parameter int                WIDTH        = 6,
    parameter int                LFSR_W       = 13,
    parameter logic [LFSR_W-1:0] LFSR_TAPS    = LFSR_W'(DEFAULT_LFSR_TAPS),
    parameter logic [LFSR_W-1:0] SEED         = '1,
    parameter int                SIG_W        = 16,
    parameter logic [SIG_W-1:0]  MISR_POLY    = SIG_W'(DEFAULT_MISR_POLY),
    parameter int                NUM_PATTERNS = 64,
    parameter int                CUT_LAT      = 0,
    parameter logic [SIG_W-1:0]  GOLDEN_SIG   = '0
) (
    input logic   clk,
    input logic   rst,
    bist_if.slave bus
);

    localparam pattern_cnt_t LAST_IDX   = pattern_cnt_t'(NUM_PATTERNS - 1);
    localparam logic [2:0]   FLUSH_LAST = 3'((CUT_LAT > 0) ? CUT_LAT - 1 : 0);

    bist_state_t       state;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_next;
    logic [SIG_W-1:0]  misr;
    logic [SIG_W-1:0]  golden;
    logic [SIG_W-1:0]  signature;
    pattern_cnt_t      pattern_idx;
    logic [2:0]        flush_cnt;
    logic              mode_learn;
    logic              busy;
    logic              done;
    logic              pass;
    logic              run_tok;
    logic              comp_en;
    logic              misr_clear;

    assign lfsr_next  = {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
    assign run_tok    = (state == ST_RUN);
    assign misr_clear = (state == ST_SEED);

    // The valid token follows each pattern through the CUT's pipeline so the
    // MISR only samples cut_resp when it belongs to an applied pattern.
    generate
        if (CUT_LAT == 0) begin : g_no_lat
            assign comp_en = run_tok;
        end else begin : g_lat
            logic [CUT_LAT-1:0] vpipe;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vpipe <= '0;
                end else if (state == ST_SEED) begin
                    vpipe <= '0;
                end else begin
                    vpipe[0] <= run_tok;
                    for (int i = 1; i < CUT_LAT; i++) begin
                        vpipe[i] <= vpipe[i-1];
                    end
                end
            end

            assign comp_en = vpipe[CUT_LAT-1];
        end
    endgenerate

    bist_misr #(
        .SIG_W (SIG_W),
        .POLY  (MISR_POLY),
        .IN_W  (WIDTH + 1)
    ) u_misr (
        .clk    (clk),
        .rst    (rst),
        .clear  (misr_clear),
        .enable (comp_en),
        .data   (bus.cut_resp),
        .sig    (misr)
    );

    // Abort only acts while busy, so a start in DONE overrides it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            lfsr        <= SEED;
            golden      <= GOLDEN_SIG;
            signature   <= '0;
            pattern_idx <= '0;
            flush_cnt   <= '0;
            mode_learn  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
        end else if (bus.abort && busy) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        mode_learn <= bus.learn;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_SEED;
                    end
                end
                ST_SEED: begin
                    lfsr        <= SEED;
                    pattern_idx <= '0;
                    flush_cnt   <= '0;
                    state       <= ST_RUN;
                end
                ST_RUN: begin
                    if (pattern_idx == LAST_IDX) begin
                        state <= (CUT_LAT == 0) ? ST_COMPARE : ST_FLUSH;
                    end else begin
                        lfsr        <= lfsr_next;
                        pattern_idx <= pattern_idx + 16'd1;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        state <= ST_COMPARE;
                    end else begin
                        flush_cnt <= flush_cnt + 3'd1;
                    end
                end
                ST_COMPARE: begin
                    signature <= misr;
                    if (mode_learn) begin
                        golden <= misr;
                        pass   <= 1'b1;
                    end else begin
                        pass <= (misr == golden);
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.tpg_a       = lfsr[WIDTH-1:0];
    assign bus.tpg_b       = lfsr[2*WIDTH-1:WIDTH];
    assign bus.tpg_cin     = lfsr[2*WIDTH];
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.pass        = pass;
    assign bus.signature   = signature;
    assign bus.pattern_idx = pattern_idx;

endmodule

// File: tb/tb_bist_engine.sv
// Scoreboard bench for bist_engine: a zero-latency and a three-cycle-latency
// engine, each beside an adder CUT, exercised by directed runs.
module tb_bist_engine;

    localparam int WIDTH = 6;
    localparam int SIG_W = 16;
    localparam int NPAT  = 64;

    typedef struct {
        int          id;
        int          done_cyc;
        logic        pass;
        logic [15:0] sig;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    exp_t q0[$];
    exp_t q1[$];

    logic        fault0 = 1'b0;
    logic        done0_d = 1'b0;
    logic        done1_d = 1'b0;
    logic [6:0]  sum0;
    logic [6:0]  c1, c2, c3;
    logic [15:0] sig_good;
    logic [15:0] sig_fault;

    bist_if #(.WIDTH(WIDTH), .SIG_W(SIG_W)) bus0 ();
    bist_if #(.WIDTH(WIDTH), .SIG_W(SIG_W)) bus1 ();

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    bist_engine #(.WIDTH(WIDTH), .NUM_PATTERNS(NPAT), .CUT_LAT(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    bist_engine #(.WIDTH(WIDTH), .NUM_PATTERNS(NPAT), .CUT_LAT(3)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    function automatic logic [6:0] addModel(input logic [5:0] a, input logic [5:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {6'b0, c};
    endfunction

    // Reference run: LFSR from all-ones seed feeding a golden adder into the MISR.
    function automatic logic [15:0] modelSig(input logic fault);
        logic [12:0] l;
        logic [15:0] m;
        logic [6:0]  r;
        l = 13'h1FFF;
        m = 16'h0000;
        for (int p = 0; p < NPAT; p++) begin
            r = addModel(l[5:0], l[11:6], l[12]);
            if (fault) r[3] = 1'b0;
            m = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {9'b0, r};
            l = {l[11:0], ^(l & 13'h1B00)};
        end
        return m;
    endfunction

    assign sum0          = addModel(bus0.tpg_a, bus0.tpg_b, bus0.tpg_cin);
    assign bus0.cut_resp = fault0 ? (sum0 & 7'b1110111) : sum0;

    always @(posedge clk) begin
        c1 <= addModel(bus1.tpg_a, bus1.tpg_b, bus1.tpg_cin);
        c2 <= c1;
        c3 <= c2;
    end
    assign bus1.cut_resp = c3;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
        end
    endtask

    task automatic compareRun(input exp_t e, input logic pass, input logic [15:0] sig);
        checkOutput($sformatf("run %0d done cycle", e.id), 64'(cyc), 64'(e.done_cyc));
        checkOutput($sformatf("run %0d pass", e.id), {63'b0, pass}, {63'b0, e.pass});
        checkOutput($sformatf("run %0d signature", e.id), {48'b0, sig}, {48'b0, e.sig});
    endtask

    // Monitors: every rising done is matched against the oldest expected run.
    always @(negedge clk) begin
        exp_t e;
        if (bus0.done && !done0_d) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL dut0 unexpected done: got done=1 at cycle %0d, required no run pending", cyc);
            end else begin
                e = q0.pop_front();
                compareRun(e, bus0.pass, bus0.signature);
            end
        end
        done0_d <= bus0.done;
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus1.done && !done1_d) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL dut1 unexpected done: got done=1 at cycle %0d, required no run pending", cyc);
            end else begin
                e = q1.pop_front();
                compareRun(e, bus1.pass, bus1.signature);
            end
        end
        done1_d <= bus1.done;
    end

    task automatic applyStimulus(input int which, input logic learnBit, input logic withAbort,
                                 input logic track, input logic expPass, input logic [15:0] expSig,
                                 input int id);
        exp_t e;
        @(negedge clk);
        if (which == 0) begin
            bus0.start = 1'b1; bus0.learn = learnBit; bus0.abort = withAbort;
        end else begin
            bus1.start = 1'b1; bus1.learn = learnBit; bus1.abort = withAbort;
        end
        @(negedge clk);
        bus0.start = 1'b0; bus0.abort = 1'b0;
        bus1.start = 1'b0; bus1.abort = 1'b0;
        e.id       = id;
        e.done_cyc = cyc + NPAT + ((which == 0) ? 0 : 3) + 2;
        e.pass     = expPass;
        e.sig      = expSig;
        if (track) begin
            if (which == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    task automatic waitRun(input int which, input int budget);
        int n;
        n = 0;
        while (((which == 0) ? q0.size() : q1.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("[TB] FAIL dut%0d run timeout: got no done in %0d cycles, required done", which, budget);
            if (which == 0) q0.delete();
            else q1.delete();
        end
    endtask

    task automatic waitIdx(input logic [15:0] target, input int budget);
        int n;
        n = 0;
        while (bus0.pattern_idx != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("[TB] FAIL dut0 pattern_idx wait: got %0d, required %0d", bus0.pattern_idx, target);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion by time limit, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [12:0] ml;
        int          nbad;

        bus0.start = 1'b0; bus0.learn = 1'b0; bus0.abort = 1'b0;
        bus1.start = 1'b0; bus1.learn = 1'b0; bus1.abort = 1'b0;
        sig_good  = modelSig(1'b0);
        sig_fault = modelSig(1'b1);

        repeat (2) @(negedge clk);
        checkOutput("dut0 reset status", {bus0.busy, bus0.done, bus0.pass, bus0.signature, bus0.pattern_idx}, 64'd0);
        checkOutput("dut0 reset tpg", {bus0.tpg_cin, bus0.tpg_b, bus0.tpg_a}, 64'h1FFF);
        checkOutput("dut1 reset status", {bus1.busy, bus1.done, bus1.pass, bus1.signature, bus1.pattern_idx}, 64'd0);
        rst = 1'b0;

        // Learn on the zero-latency engine while tracing the pattern stream.
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 1'b1, sig_good, 1);
        @(negedge clk);
        checkOutput("first pattern tpg", {bus0.tpg_b, bus0.tpg_a, bus0.tpg_cin}, {51'b0, 6'h3F, 6'h3F, 1'b1});
        checkOutput("first pattern idx/busy", {bus0.pattern_idx, bus0.busy}, {47'b0, 16'd0, 1'b1});
        @(negedge clk);
        checkOutput("second pattern tpg", {bus0.tpg_b, bus0.tpg_a, bus0.tpg_cin}, {51'b0, 6'h3F, 6'h3E, 1'b1});
        ml   = 13'h1FFE;
        nbad = 0;
        for (int k = 1; k < NPAT; k++) begin
            if (k > 1) @(negedge clk);
            if (bus0.pattern_idx != 16'(k) || {bus0.tpg_cin, bus0.tpg_b, bus0.tpg_a} != ml) nbad++;
            ml = {ml[11:0], ^(ml & 13'h1B00)};
        end
        checkOutput("pattern sequence mismatches", 64'(nbad), 64'd0);
        waitRun(0, 200);
        repeat (4) @(negedge clk);
        checkOutput("done held", {63'b0, bus0.done}, 64'd1);
        checkOutput("signature held", {48'b0, bus0.signature}, {48'b0, sig_good});

        // Check run with a start pulse mid-run that must be ignored.
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b1, sig_good, 2);
        waitIdx(16'd30, 100);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        waitRun(0, 200);

        // Faulty CUT; start and abort together in DONE, start wins.
        fault0 = 1'b1;
        applyStimulus(0, 1'b0, 1'b1, 1'b1, 1'b0, sig_fault, 3);
        waitRun(0, 200);
        fault0 = 1'b0;

        // Registered three-stage CUT: learn then check.
        applyStimulus(1, 1'b1, 1'b0, 1'b1, 1'b1, sig_good, 4);
        waitRun(1, 200);
        applyStimulus(1, 1'b0, 1'b0, 1'b1, 1'b1, sig_good, 5);
        waitRun(1, 200);

        // Abort at pattern 20; golden must survive.
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 6);
        waitIdx(16'd5, 100);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        waitIdx(16'd20, 100);
        bus0.abort = 1'b1;
        @(negedge clk);
        bus0.abort = 1'b0;
        checkOutput("abort status", {61'b0, bus0.busy, bus0.done, bus0.pass}, 64'd0);
        repeat (70) @(negedge clk);
        checkOutput("abort stays idle", {62'b0, bus0.busy, bus0.done}, 64'd0);
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b1, sig_good, 7);
        waitRun(0, 200);

        // Asynchronous reset mid-run drops the learned golden.
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 8);
        waitIdx(16'd10, 100);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid-run reset status", {bus0.busy, bus0.done, bus0.pass, bus0.signature, bus0.pattern_idx}, 64'd0);
        checkOutput("mid-run reset tpg", {bus0.tpg_cin, bus0.tpg_b, bus0.tpg_a}, 64'h1FFF);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 1'b1, 1'b0, sig_good, 9);
        waitRun(0, 200);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
